// File: rtl/i2c_master.sv
// Single-master I2C/SCCB controller: one 8-bit register write or read per request.
// Open-drain style drive (1 = release), quarter-period bit timing with clock stretching.
module i2c_master #(
   parameter int T_CLK = 10,
   parameter int F_SCL = 100_000
) (
   input  logic       i_clk,
   input  logic       i_rstn,
   input  logic       i_wr,
   input  logic       i_rd,
   input  logic [6:0] i_slave_addr,
   input  logic [7:0] i_reg_addr,
   input  logic [7:0] i_wdata,
   output logic [7:0] o_rdata,
   output logic       o_busy,
   output logic       o_rdata_valid,
   output logic       o_nack_slave,
   output logic       o_nack_addr,
   output logic       o_nack_data,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_scl,
   output logic       o_sda
);
   localparam int QTR = 1_000_000_000 / (T_CLK * F_SCL * 4);
   localparam int QW  = $clog2(QTR + 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_BYTE, S_RSTART, S_STOP} state_t;

   state_t          r_state, w_next;
   logic [QW-1:0]   r_qcnt;
   logic [1:0]      r_q;
   logic [3:0]      r_bit;
   logic [1:0]      r_byte;
   logic            r_is_rd;
   logic [6:0]      r_slave;
   logic [7:0]      r_reg, r_wdata, r_rx, r_rdata;
   logic            r_rdata_valid, r_nack_slave, r_nack_addr, r_nack_data;
   logic            w_scl, w_sda, w_stretch, w_tick, w_unit_end, w_sample, w_start_req;
   logic [7:0]      w_txbyte;

   assign w_start_req = (r_state == S_IDLE) && (i_wr || i_rd);
   // A slave holding SCL low while we release it freezes the quarter timer.
   assign w_stretch   = w_scl && !i_scl;
   assign w_tick      = (r_state != S_IDLE) && (r_qcnt == QW'(QTR - 1)) && !w_stretch;
   assign w_unit_end  = w_tick && (r_q == 2'd3);
   assign w_sample    = w_tick && (r_q == 2'd2) && (r_state == S_BYTE);

   always_ff @(posedge i_clk) begin
      if (!i_rstn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:           if (i_wr || i_rd) w_next = S_START;
         S_START, S_RSTART: if (w_unit_end) w_next = S_BYTE;
         S_BYTE: begin
            if (w_unit_end && r_bit == 4'd8) begin
               if (!r_is_rd && r_byte == 2'd2)     w_next = S_STOP;
               else if (r_is_rd && r_byte == 2'd3) w_next = S_STOP;
               else if (r_is_rd && r_byte == 2'd1) w_next = S_RSTART;
            end
         end
         S_STOP:           if (w_unit_end) w_next = S_IDLE;
         default:          w_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_scl = 1'b1;
      w_sda = 1'b1;
      case (r_byte)
         2'd0:    w_txbyte = {r_slave, 1'b0};
         2'd1:    w_txbyte = r_reg;
         2'd2:    w_txbyte = r_is_rd ? {r_slave, 1'b1} : r_wdata;
         default: w_txbyte = 8'hFF;
      endcase
      case (r_state)
         S_START: begin
            w_sda = (r_q == 2'd0);
            w_scl = (r_q != 2'd3);
         end
         S_BYTE: begin
            // ACK slots, the read-data byte and its master NACK all leave SDA released.
            w_scl = r_q[1];
            w_sda = (r_bit == 4'd8 || r_byte == 2'd3) ? 1'b1 : w_txbyte[3'd7 - r_bit[2:0]];
         end
         S_RSTART: begin
            w_scl = (r_q == 2'd1) || (r_q == 2'd2);
            w_sda = (r_q <= 2'd1);
         end
         S_STOP: begin
            w_scl = (r_q != 2'd0);
            w_sda = r_q[1];
         end
         default: begin
            w_scl = 1'b1;
            w_sda = 1'b1;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_qcnt        <= '0;
         r_q           <= 2'd0;
         r_bit         <= 4'd0;
         r_byte        <= 2'd0;
         r_is_rd       <= 1'b0;
         r_rx          <= 8'd0;
         r_rdata       <= 8'd0;
         r_rdata_valid <= 1'b0;
         r_nack_slave  <= 1'b0;
         r_nack_addr   <= 1'b0;
         r_nack_data   <= 1'b0;
      end else begin
         r_rdata_valid <= 1'b0;
         if (w_start_req) begin
            r_is_rd      <= !i_wr;
            r_slave      <= i_slave_addr;
            r_reg        <= i_reg_addr;
            r_wdata      <= i_wdata;
            r_qcnt       <= '0;
            r_q          <= 2'd0;
            r_bit        <= 4'd0;
            r_byte       <= 2'd0;
            r_nack_slave <= 1'b0;
            r_nack_addr  <= 1'b0;
            r_nack_data  <= 1'b0;
         end else if (r_state != S_IDLE) begin
            if (w_tick) begin
               r_qcnt <= '0;
               r_q    <= r_q + 2'd1;
            end else if (!w_stretch) begin
               r_qcnt <= r_qcnt + 1'b1;
            end
            if (w_unit_end && r_state == S_BYTE) begin
               if (r_bit == 4'd8) begin
                  r_bit  <= 4'd0;
                  r_byte <= r_byte + 2'd1;
               end else begin
                  r_bit  <= r_bit + 4'd1;
               end
            end
            if (w_sample) begin
               if (r_bit != 4'd8) begin
                  if (r_byte == 2'd3) r_rx <= {r_rx[6:0], i_sda};
               end else if (i_sda) begin
                  case (r_byte)
                     2'd0:    r_nack_slave <= 1'b1;
                     2'd1:    r_nack_addr  <= 1'b1;
                     2'd2:    if (r_is_rd) r_nack_slave <= 1'b1; else r_nack_data <= 1'b1;
                     default: ;
                  endcase
               end
            end
            if (w_unit_end && r_state == S_STOP && r_is_rd) begin
               r_rdata       <= r_rx;
               r_rdata_valid <= 1'b1;
            end
         end
      end
   end

   assign o_scl         = w_scl;
   assign o_sda         = w_sda;
   assign o_busy        = (r_state != S_IDLE);
   assign o_rdata       = r_rdata;
   assign o_rdata_valid = r_rdata_valid;
   assign o_nack_slave  = r_nack_slave;
   assign o_nack_addr   = r_nack_addr;
   assign o_nack_data   = r_nack_data;
endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master: a bus decoder/slave model reports START, STOP,
// bytes with their ACK bit, read data, NACK flags and busy length against a queue.
module tb_i2c_master;
   localparam int T_CLK = 10;
   localparam int F_SCL = 1_000_000;
   localparam int QTR   = 25;
   localparam int K_START = 0, K_BYTE = 1, K_STOP = 2, K_RDATA = 3, K_FLAGS = 4,
                  K_BUSY = 5, K_VALID = 6;

   logic       clk = 1'b0, rstn = 1'b0, wr = 1'b0, rd = 1'b0;
   logic [6:0] sa = 7'd0;
   logic [7:0] ra = 8'd0, wd = 8'd0;
   logic [7:0] o_rdata;
   logic       o_busy, o_rdata_valid, o_nack_slave, o_nack_addr, o_nack_data, o_scl, o_sda;
   logic       sl_sda = 1'b1, scl_hold = 1'b1;
   wire        bus_scl = o_scl & scl_hold;
   wire        bus_sda = o_sda & sl_sda;

   always #5 clk = ~clk;

   i2c_master #(.T_CLK(T_CLK), .F_SCL(F_SCL)) dut (
      .i_clk(clk), .i_rstn(rstn), .i_wr(wr), .i_rd(rd),
      .i_slave_addr(sa), .i_reg_addr(ra), .i_wdata(wd),
      .o_rdata(o_rdata), .o_busy(o_busy), .o_rdata_valid(o_rdata_valid),
      .o_nack_slave(o_nack_slave), .o_nack_addr(o_nack_addr), .o_nack_data(o_nack_data),
      .i_scl(bus_scl), .i_sda(bus_sda), .o_scl(o_scl), .o_sda(o_sda)
   );

   typedef struct {int kind; int val;} ev_t;
   ev_t  exp_q[$];
   int   n_tests = 0, n_fail = 0;
   bit   mon_en = 1'b0, ack_en = 1'b1;
   logic [7:0] rd_byte = 8'd0;

   function automatic string kname(int k);
      case (k)
         K_START: return "start";
         K_BYTE:  return "byte_ack";
         K_STOP:  return "stop";
         K_RDATA: return "rdata";
         K_FLAGS: return "nack_flags";
         K_BUSY:  return "busy_cycles";
         default: return "stray_valid";
      endcase
   endfunction

   function automatic void push(int k, int v);
      exp_q.push_back('{kind: k, val: v});
   endfunction

   function automatic void observe(int k, int v);
      ev_t e;
      bit  ok;
      n_tests++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL unexpected_%s: got 0x%0h, required no event", kname(k), v);
      end else begin
         e  = exp_q.pop_front();
         ok = (e.kind == k) && ((k == K_BUSY) ? (v >= e.val - 2 && v <= e.val + 2) : (v == e.val));
         if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %s 0x%0h, required %s 0x%0h", kname(e.kind), kname(k), v,
                     kname(e.kind), e.val);
         end
      end
   endfunction

   task automatic check(input string name, input int act, input int req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Bus decoder plus slave model (ACKs master bytes, returns rd_byte on reads).
   logic p_scl = 1'b1, p_sda = 1'b1, p_busy = 1'b0;
   int   busy_cnt = 0;
   bit [3:0] bitcnt = 4'd0;
   bit [7:0] sh = 8'd0;
   bit       first = 1'b0, rdm = 1'b0;

   always @(negedge clk) begin
      if (!mon_en) begin
         bitcnt = 4'd0; first = 1'b0; rdm = 1'b0; sl_sda = 1'b1; busy_cnt = 0;
      end else begin
         if (p_scl && bus_scl && p_sda && !bus_sda) begin
            observe(K_START, 0);
            bitcnt = 4'd0; first = 1'b1; rdm = 1'b0; sl_sda = 1'b1;
         end else if (p_scl && bus_scl && !p_sda && bus_sda) begin
            observe(K_STOP, 0);
            bitcnt = 4'd0; sl_sda = 1'b1;
         end else if (!p_scl && bus_scl) begin
            if (bitcnt < 4'd8) begin
               sh = {sh[6:0], bus_sda};
               bitcnt++;
            end else begin
               observe(K_BYTE, {sh, bus_sda});
               rdm    = first ? sh[0] : 1'b0;
               first  = 1'b0;
               bitcnt = 4'd0;
            end
         end else if (p_scl && !bus_scl) begin
            if (bitcnt == 4'd8 && !rdm)     sl_sda = ack_en ? 1'b0 : 1'b1;
            else if (rdm && bitcnt < 4'd8)  sl_sda = rd_byte[3'd7 - bitcnt[2:0]];
            else                            sl_sda = 1'b1;
         end
         if (o_busy) busy_cnt++;
         if (p_busy && !o_busy) begin
            if (o_rdata_valid) observe(K_RDATA, o_rdata);
            observe(K_FLAGS, {o_nack_slave, o_nack_addr, o_nack_data});
            observe(K_BUSY, busy_cnt);
            busy_cnt = 0;
         end else if (o_rdata_valid) begin
            observe(K_VALID, o_rdata);
         end
      end
      p_scl  = bus_scl;
      p_sda  = bus_sda;
      p_busy = o_busy;
   end

   task automatic push_write(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input bit ack, input int extra);
      push(K_START, 0);
      push(K_BYTE, {b0, !ack});
      push(K_BYTE, {b1, !ack});
      push(K_BYTE, {b2, !ack});
      push(K_STOP, 0);
      push(K_FLAGS, ack ? 0 : 3'b111);
      push(K_BUSY, 116 * QTR + extra);
   endtask

   task automatic issue(input bit w, input bit r, input logic [6:0] s, input logic [7:0] a,
                        input logic [7:0] d);
      @(negedge clk);
      wr = w; rd = r; sa = s; ra = a; wd = d;
      @(negedge clk);
      wr = 1'b0; rd = 1'b0; sa = 7'h55; ra = 8'hAA; wd = 8'h33;
      check("busy_after_accept", o_busy, 1);
   endtask

   task automatic wait_done(input int budget);
      int c = 0;
      while (o_busy && c < budget) begin
         @(negedge clk);
         c++;
      end
      if (o_busy) begin
         n_tests++;
         n_fail++;
         $display("FAIL busy_timeout: got busy after %0d cycles, required idle", c);
      end
      repeat (20) @(negedge clk);
   endtask

   task automatic wait_scl(input logic lvl, input int budget);
      int c = 0;
      while (o_scl !== lvl && c < budget) begin
         @(negedge clk);
         c++;
      end
      check("scl_edge_seen", o_scl, lvl);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_scl", o_scl, 1);
      check("rst_sda", o_sda, 1);
      check("rst_busy", o_busy, 0);
      check("rst_rdata", o_rdata, 0);
      check("rst_valid", o_rdata_valid, 0);
      check("rst_flags", {o_nack_slave, o_nack_addr, o_nack_data}, 0);
      rstn = 1'b1;
      repeat (5) @(negedge clk);
      mon_en = 1'b1;
      repeat (5) @(negedge clk);

      // Plain write: 0x42 -> address byte 0x84.
      push_write(8'h84, 8'h12, 8'h80, 1'b1, 0);
      issue(1'b1, 1'b0, 7'h42, 8'h12, 8'h80);
      wait_done(200 * QTR);

      // Read with repeated START; slave returns 0x76, master NACKs it.
      rd_byte = 8'h76;
      push(K_START, 0);
      push(K_BYTE, {8'h84, 1'b0});
      push(K_BYTE, {8'h0A, 1'b0});
      push(K_START, 0);
      push(K_BYTE, {8'h85, 1'b0});
      push(K_BYTE, {8'h76, 1'b1});
      push(K_STOP, 0);
      push(K_RDATA, 'h76);
      push(K_FLAGS, 0);
      push(K_BUSY, 156 * QTR);
      issue(1'b0, 1'b1, 7'h42, 8'h0A, 8'h00);
      wait_done(200 * QTR);
      check("rdata_held", o_rdata, 'h76);

      // Slave never ACKs: full write and STOP still occur, all flags stick.
      ack_en = 1'b0;
      push_write(8'h84, 8'h12, 8'h80, 1'b0, 0);
      issue(1'b1, 1'b0, 7'h42, 8'h12, 8'h80);
      wait_done(200 * QTR);
      ack_en = 1'b1;
      check("flags_sticky", {o_nack_slave, o_nack_addr, o_nack_data}, 3'b111);

      // wr+rd together: write wins; flags clear; later requests while busy are ignored.
      push_write(8'h78, 8'hA5, 8'h3C, 1'b1, 0);
      issue(1'b1, 1'b1, 7'h3C, 8'hA5, 8'h3C);
      check("flags_clear_on_accept", {o_nack_slave, o_nack_addr, o_nack_data}, 0);
      repeat (20 * QTR) @(negedge clk);
      wr = 1'b1; rd = 1'b1;
      @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      repeat (30 * QTR) @(negedge clk);
      wr = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      wait_done(200 * QTR);
      repeat (10 * QTR) @(negedge clk);
      check("no_extra_transfer", o_busy, 0);

      // Clock stretch of 1000 cycles starting as SCL is released in a data bit.
      push_write(8'h42, 8'h00, 8'hFF, 1'b1, 1000);
      issue(1'b1, 1'b0, 7'h21, 8'h00, 8'hFF);
      repeat (10 * QTR) @(negedge clk);
      wait_scl(1'b0, 4 * QTR);
      wait_scl(1'b1, 4 * QTR);
      scl_hold = 1'b0;
      repeat (1000) @(negedge clk);
      scl_hold = 1'b1;
      wait_done(200 * QTR);

      // Reset in the middle of a byte, then a fresh write.
      mon_en = 1'b0;
      issue(1'b1, 1'b0, 7'h42, 8'h12, 8'h80);
      repeat (30 * QTR) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      check("midrst_scl", o_scl, 1);
      check("midrst_sda", o_sda, 1);
      check("midrst_busy", o_busy, 0);
      check("midrst_rdata", o_rdata, 0);
      rstn = 1'b1;
      repeat (20) @(negedge clk);
      mon_en = 1'b1;
      repeat (5) @(negedge clk);
      push_write(8'hFE, 8'h01, 8'h5A, 1'b1, 0);
      issue(1'b1, 1'b0, 7'h7F, 8'h01, 8'h5A);
      wait_done(200 * QTR);

      check("events_outstanding", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
